idct_pixel_serializer: RTL
==========================

# idct_pixel_serializer

Downstream stage of the 8x8 IDCT array. Accepts one fully transformed 64-sample block (2048 bits, 64 × 32-bit signed) per handshake and applies the JPEG level shift (+128). It clamps each sample to 0..255, buffers the block, and streams the 64 pixels out one per cycle in row-major order with a valid/ready handshake. Its output feeds the MCU/colour-conversion path.

## Interface
- DATA_W, 32: width of one signed IDCT output sample.
- LEVEL_SHIFT, 128: constant added to every sample before clamping.

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- data_in  in  64*DATA_W (2048)  IDCT block. Sample k (row r = k/8, col c = k%8) is at data_in[DATA_W*k +: DATA_W]. Row r occupies data_in[256r +: 256].
- s_valid  in  1  data_in holds a complete block.
- s_ready  out  1  block accepted on a cycle where s_valid && s_ready.
- m_data  out  8  current pixel, unsigned.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  downstream takes the pixel on a cycle where m_valid && m_ready.
- m_last  out  1  high with the 64th pixel (k = 63) of a block.
- m_index  out  6  index k of the current pixel.

## Operation
- State:
  - full flag (buffer holds an unfinished block).
  - 6-bit pixel counter idx.
  - 64 × 8-bit pixel buffer.
- Conversion happens at capture, for each k:
  - sum = sign-extend(sample_k) to DATA_W+1 bits + LEVEL_SHIFT.
  - If sum < 0, pix = 0. If sum > 255, pix = 255. Otherwise pix = sum[7:0].
  - No wrap-around is permitted. 0x7FFFFFFF gives 255, and 0x80000000 gives 0.
- Capture happens when s_valid && s_ready: the buffer is loaded with all 64 pixels, full is set to 1, and idx is set to 0.
- Output wiring is combinational from registered state:
  - m_valid = full
  - m_data = buffer[idx]
  - m_index = idx
  - m_last = full && (idx == 63)
- Pixel transfer happens when m_valid && m_ready:
  - If idx < 63, idx increments.
  - If idx == 63, idx wraps to 0 and full clears, unless a new block is captured in the same cycle.
- s_ready = !full || (m_ready && idx == 63). This allows a back-to-back block with no bubble.
- Simultaneous last-pixel transfer and capture: the capture wins. The buffer is reloaded, full stays 1, idx = 0.
- Stall: while m_valid && !m_ready, m_data, m_index and m_last hold. The buffer is never overwritten while full, except in the simultaneous case above.
- s_valid while !s_ready: the block is ignored. Upstream must hold data_in.

## Timing
- Reset (rst high at an edge):
  - full = 0, idx = 0, buffer cleared to 0.
  - After that edge: m_valid = 0, m_last = 0, m_data = 0, m_index = 0, s_ready = 1.
- Reset mid-block: the partial block is discarded. No further pixels are emitted and nothing is replayed.
- Latency: capture at edge N gives pixel 0 valid in cycle N+1.
- Throughput: with m_ready held high, 64 pixels take 64 consecutive cycles. Back-to-back blocks give a continuous pixel stream (1 pixel per cycle).
- m_last is asserted for exactly one accepted transfer per block.
- No combinational path from data_in or s_valid to any output. s_ready depends combinationally on m_ready only.

## Test plan
- All-zero block, m_ready = 1:
  - Capture is followed by 64 pixels of value 128 in consecutive cycles, m_index 0..63.
  - m_last only at index 63; m_valid drops the next cycle.
- Ramp, sample k = k − 128 (k = 0..63): pixel k = k in row-major order. Repeat with sample k = 64 + k + 63: pixels 255 (clamped) for all k.
- Extreme values at sample 0 of four blocks:
  - −200 gives 0.
  - 500 gives 255.
  - 0x7FFFFFFF gives 255.
  - 0x80000000 gives 0.
- Random m_ready backpressure:
  - Output equals the model stream.
  - m_data is stable during stalls.
  - s_ready stays low and no second capture occurs until pixel 63 is taken.
- Two blocks offered continuously: block B is accepted in the same cycle as A's pixel 63. B's pixel 0 follows with no idle cycle.
- rst asserted after pixel 20 of a block:
  - Next cycle m_valid = 0 and s_ready = 1.
  - A new block then streams from index 0 with no stale pixels.

Source files
------------

// File: rtl/idct_pixel_serializer_if.sv
// Block-in / pixel-out handshake bundle for the IDCT pixel serializer.
// master = upstream block source plus downstream pixel sink; slave = serializer.
interface idct_pixel_serializer_if #(
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned N_PIX = 64;
    localparam int unsigned PIX_W = 8;
    localparam int unsigned IDX_W = 6;

    logic [N_PIX*DATA_W-1:0] data_in;
    logic                    s_valid;
    logic                    s_ready;
    logic [PIX_W-1:0]        m_data;
    logic                    m_valid;
    logic                    m_ready;
    logic                    m_last;
    logic [IDX_W-1:0]        m_index;

    modport master (
        output data_in, s_valid, m_ready,
        input  s_ready, m_data, m_valid, m_last, m_index
    );

    modport slave (
        input  data_in, s_valid, m_ready,
        output s_ready, m_data, m_valid, m_last, m_index
    );
endinterface

// File: rtl/idct_pixel_serializer.sv
// Level-shifts and clamps a 64-sample IDCT block at capture, then streams the
// 8-bit pixels out one per cycle in row-major order.
module idct_pixel_serializer #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned LEVEL_SHIFT = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    idct_pixel_serializer_if.slave bus
);
    localparam int unsigned N_PIX = 64;
    localparam int unsigned PIX_W = 8;
    localparam int unsigned IDX_W = 6;
    localparam int unsigned SUM_W = DATA_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [PIX_W-1:0] pix_q [N_PIX];
    logic [PIX_W-1:0] pix_d [N_PIX];
    logic             capture;
    logic             take;

    // One extra sum bit keeps extreme samples from wrapping before the clamp.
    function automatic logic [PIX_W-1:0] clamp_pixel(input logic [DATA_W-1:0] sample);
        logic [SUM_W-1:0] sum;
        sum = {sample[DATA_W-1], sample} + SUM_W'(LEVEL_SHIFT);
        if (sum[SUM_W-1])
            return '0;
        else if (|sum[SUM_W-2:PIX_W])
            return '1;
        else
            return sum[PIX_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            idx_q   <= '0;
            for (int k = 0; k < int'(N_PIX); k++) pix_q[k] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pix_q   <= pix_d;
        end
    end

    // Next state: a capture always wins over the last-pixel release.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pix_d   = pix_q;
        capture = bus.s_valid && bus.s_ready;
        take    = bus.m_valid && bus.m_ready;
        if (capture) begin
            state_d = ST_FULL;
            idx_d   = '0;
            for (int k = 0; k < int'(N_PIX); k++)
                pix_d[k] = clamp_pixel(bus.data_in[DATA_W*k +: DATA_W]);
        end else if (take) begin
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) state_d = ST_EMPTY;
        end
    end

    // Outputs come from registered state; s_ready additionally sees m_ready.
    always_comb begin
        bus.s_ready = 1'b1;
        bus.m_valid = 1'b0;
        bus.m_last  = 1'b0;
        bus.m_data  = pix_q[idx_q];
        bus.m_index = idx_q;
        if (state_q == ST_FULL) begin
            bus.m_valid = 1'b1;
            bus.m_last  = (idx_q == LAST_IDX);
            bus.s_ready = bus.m_ready && (idx_q == LAST_IDX);
        end
    end
endmodule
